instr_fetch_unit: RTL



---
 rtl/pampy_pkg.sv | 15 +
 rtl/instr_fetch_unit_if.sv | 36 +++
 rtl/fetch_fifo.sv | 62 ++++++
 rtl/instr_fetch_unit.sv | 114 +++++++++++
 4 files changed

// File: rtl/pampy_pkg.sv
// rtl/pampy_pkg.sv - shared fetch-stage types and instruction field positions
package pampy_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 8;
    localparam int ARG_MSB = 7;
    localparam int ARG_LSB = 0;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - program memory and core-side handshakes of the fetch stage
interface instr_fetch_unit_if #(
    parameter int DATA_WIDTH        = 8,
    parameter int ADDR_WIDTH        = 12,
    parameter int INSTRUCTION_WIDTH = 16
);
    logic                         FETCH_EN;
    logic                         REDIRECT_VALID;
    logic [ADDR_WIDTH-1:0]        REDIRECT_ADDR;
    logic                         MEM_REQ;
    logic [ADDR_WIDTH-1:0]        MEM_ADDR;
    logic                         MEM_GNT;
    logic                         MEM_RVALID;
    logic [INSTRUCTION_WIDTH-1:0] MEM_RDATA;
    logic                         INSTR_VALID;
    logic                         INSTR_READY;
    logic [DATA_WIDTH-1:0]        INSTR_OUT;
    logic [DATA_WIDTH-1:0]        ARG_OUT;
    logic [ADDR_WIDTH-1:0]        INSTR_PC;
    logic [ADDR_WIDTH-1:0]        FETCH_PC;
    logic                         ERR_OUT;

    modport master (
        input  FETCH_EN, REDIRECT_VALID, REDIRECT_ADDR,
        input  MEM_GNT, MEM_RVALID, MEM_RDATA, INSTR_READY,
        output MEM_REQ, MEM_ADDR, INSTR_VALID, INSTR_OUT, ARG_OUT,
        output INSTR_PC, FETCH_PC, ERR_OUT
    );

    modport slave (
        output FETCH_EN, REDIRECT_VALID, REDIRECT_ADDR,
        output MEM_GNT, MEM_RVALID, MEM_RDATA, INSTR_READY,
        input  MEM_REQ, MEM_ADDR, INSTR_VALID, INSTR_OUT, ARG_OUT,
        input  INSTR_PC, FETCH_PC, ERR_OUT
    );
endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO with flush and a registered head entry
module fetch_fifo #(
    parameter int WIDTH = 28,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_next;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full       = (count == CNT_W'(DEPTH));
    assign head_valid = (count != '0);
    assign do_pop     = pop & ~flush & head_valid;
    assign do_push    = push & ~flush & (~full | do_pop);
    assign rd_next    = rd_ptr + PTR_W'(do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            head_data <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            rd_ptr <= rd_next;
            count  <= count + CNT_W'(do_push) - CNT_W'(do_pop);
            // The new head is either already stored or is the word being written now.
            if (do_push && (wr_ptr == rd_next)) begin
                head_data <= push_data;
            end else if (do_pop) begin
                head_data <= mem[rd_next];
            end
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - in-order instruction fetch with credit-limited buffering and redirect drain
module instr_fetch_unit
    import pampy_pkg::*;
#(
    parameter int DATA_WIDTH        = 8,
    parameter int ADDR_WIDTH        = 12,
    parameter int INSTRUCTION_WIDTH = 16,
    parameter int FIFO_DEPTH        = 4
) (
    input  logic                clk,
    input  logic                reset,
    instr_fetch_unit_if.master  bus
);
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int ENTRY_W = ADDR_WIDTH + INSTRUCTION_WIDTH;

    fetch_state_t          state;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] resp_pc;
    logic [CNT_W-1:0]      out_cnt;
    logic [CNT_W-1:0]      out_cnt_next;
    logic [CNT_W-1:0]      fifo_count;
    logic [CNT_W:0]        credit_used;
    logic                  err;

    logic                  redirect;
    logic                  mem_req;
    logic                  issue;
    logic                  rsp_live;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  head_valid;
    logic [ENTRY_W-1:0]    head_data;
    logic [DATA_WIDTH-1:0] opc_field;
    logic [DATA_WIDTH-1:0] arg_field;

    assign redirect     = bus.REDIRECT_VALID;
    // Credit uses registered counts only, so a same-cycle pop does not free a slot.
    assign credit_used  = {1'b0, fifo_count} + {1'b0, out_cnt};
    assign mem_req      = (state == RUN) & ~redirect & (credit_used < (CNT_W+1)'(FIFO_DEPTH));
    assign issue        = mem_req & bus.MEM_GNT;
    assign rsp_live     = bus.MEM_RVALID & (out_cnt != '0);
    assign fifo_push    = rsp_live & ~redirect & (state != DRAIN);
    assign fifo_pop     = head_valid & bus.INSTR_READY;
    assign out_cnt_next = out_cnt + CNT_W'(issue) - CNT_W'(rsp_live);

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect),
        .push       (fifo_push),
        .push_data  ({resp_pc, bus.MEM_RDATA}),
        .pop        (fifo_pop),
        .head_data  (head_data),
        .head_valid (head_valid),
        .count      (fifo_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc <= '0;
            resp_pc  <= '0;
            out_cnt  <= '0;
            err      <= 1'b0;
        end else begin
            out_cnt <= out_cnt_next;
            if (bus.MEM_RVALID && (out_cnt == '0)) begin
                err <= 1'b1;
            end
            if (redirect) begin
                fetch_pc <= bus.REDIRECT_ADDR;
                resp_pc  <= bus.REDIRECT_ADDR;
            end else begin
                if (issue)     fetch_pc <= fetch_pc + ADDR_WIDTH'(1);
                if (fifo_push) resp_pc  <= resp_pc + ADDR_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else if (redirect) begin
            // Responses still in flight belong to the old stream and must be drained first.
            if (out_cnt_next != '0)  state <= DRAIN;
            else if (bus.FETCH_EN)   state <= RUN;
            else                     state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (bus.FETCH_EN)  state <= RUN;
                RUN:     if (!bus.FETCH_EN) state <= IDLE;
                DRAIN:   if (out_cnt_next == '0) state <= bus.FETCH_EN ? RUN : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign opc_field       = head_data[OPC_MSB:OPC_LSB];
    assign arg_field       = head_data[ARG_MSB:ARG_LSB];

    assign bus.MEM_REQ     = mem_req;
    assign bus.MEM_ADDR    = fetch_pc;
    assign bus.FETCH_PC    = fetch_pc;
    assign bus.INSTR_VALID = head_valid;
    assign bus.INSTR_OUT   = opc_field;
    assign bus.ARG_OUT     = arg_field;
    assign bus.INSTR_PC    = head_data[ENTRY_W-1:INSTRUCTION_WIDTH];
    assign bus.ERR_OUT     = err;

endmodule
